// File: rtl/mul_unit.sv
// -----------------------------------------------------------------------------
// mul_unit -- 32x32 integer multiplier returning the low 32 bits of the product.
// This is the MUL execution unit of the processor datapath. The low half of the
// product is the same for signed and unsigned operands, so one datapath serves
// both. The unit is fully pipelined and has no handshake: it accepts a new
// operand pair on every rising edge.
//
// Datapath:
//   Radix-4 Booth recoding of b (zero-extended to 33 bits) -> 17 partial
//   products, each truncated to 32 bits -> 3:2 carry-save tree down to
//   sum/carry -> one 32-bit carry-propagate add into the registered output.
//   Carries out of bit 31 are dropped at every stage.
//
// Build option:
//   MUL_UNIT_PIPE_EN  defined   : the CSA sum/carry pair is registered
//                                 (latency 2 edges).
//                     undefined : the CSA tree and the final adder form one
//                                 combinational path into out (latency 1 edge).
//   The arithmetic result and the reset values are identical in both builds.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   synchronous active-low reset; clears every pipeline register
//   a      in  32   multiplicand
//   b      in  32   multiplier
//   out    out 32   registered (a * b) mod 2^32
// -----------------------------------------------------------------------------
module mul_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out
);

  localparam int NUM_PP = 17;

  logic [31:0] w_pp [NUM_PP];
  logic [31:0] w_sum;
  logic [31:0] w_carry;
  logic [31:0] w_add;
  logic [31:0] r_out;

  // Booth recoding. Group i examines {b[2i+1], b[2i], b[2i-1]}. A zero is
  // appended below b[0] and two zeros above b[31], which makes group 16 see
  // b as an unsigned 33-bit value.
  always_comb begin
    logic [34:0] b_ext;
    logic [2:0]  grp;
    logic        one;
    logic        two;
    logic        neg;
    logic [31:0] mag;
    // NOTE: every variable driven in always_comb receives a value on every
    // path before it is read. This prevents a latch from being inferred.
    b_ext = {2'b00, b, 1'b0};
    grp   = 3'b000;
    one   = 1'b0;
    two   = 1'b0;
    neg   = 1'b0;
    mag   = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      grp = b_ext[2*i +: 3];
      one = grp[1] ^ grp[0];
      two = (grp[2] & ~grp[1] & ~grp[0]) | (~grp[2] & grp[1] & grp[0]);
      neg = grp[2];
      mag = one ? a : (two ? {a[30:0], 1'b0} : 32'd0);
      // Negation is two's complement modulo 2^32. Digit 0 on a 111 group
      // gives mag = 0, and the negation of 0 is still 0.
      w_pp[i] = (neg ? (~mag + 32'd1) : mag) << (2 * i);
    end
  end

  // Carry-save tree. Each level packs the rows in groups of three through 3:2
  // compressors and passes leftover rows straight through. The row count goes
  // 17 -> 12 -> 8 -> 6 -> 4 -> 3 -> 2.
  always_comb begin
    logic [31:0] cur [NUM_PP];
    logic [31:0] nxt [NUM_PP];
    int          n;
    int          m;
    cur = w_pp;
    nxt = cur;
    n   = NUM_PP;
    m   = 0;
    for (int lvl = 0; lvl < 6; lvl++) begin
      for (int k = 0; k < NUM_PP; k++) nxt[k] = '0;
      m = 0;
      for (int g = 0; g < 5; g++) begin
        if (3 * g + 2 < n) begin
          nxt[m]     = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
          nxt[m + 1] = ((cur[3*g] & cur[3*g+1]) | (cur[3*g] & cur[3*g+2]) |
                        (cur[3*g+1] & cur[3*g+2])) << 1;
          m = m + 2;
        end
      end
      for (int r = 0; r < NUM_PP; r++) begin
        if (r >= 3 * (n / 3) && r < n) begin
          nxt[m] = cur[r];
          m = m + 1;
        end
      end
      cur = nxt;
      n   = m;
    end
    w_sum   = cur[0];
    w_carry = cur[1];
  end

`ifdef MUL_UNIT_PIPE_EN
  logic [31:0] r_sum;
  logic [31:0] r_carry;

  // NOTE: rst_n is sampled only on the clock edge. It is therefore checked
  // inside the posedge block and does not appear in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments. All registers
      // then update together at the edge, regardless of statement order.
      r_sum   <= '0;
      r_carry <= '0;
    end else begin
      r_sum   <= w_sum;
      r_carry <= w_carry;
    end
  end

  assign w_add = r_sum + r_carry;
`else
  assign w_add = w_sum + w_carry;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_out <= '0;
    else        r_out <= w_add;
  end

  assign out = r_out;

endmodule

// File: tb/tb_mul_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_unit -- scoreboard bench for mul_unit.
//
// The driver applies one operand pair per cycle and pushes the arithmetic
// expectation for that edge into the scoreboard queue:
//   - the low 32 bits of the full 64-bit product, and
//   - whether reset was asserted on that edge.
// The monitor pops one entry per clock edge. It keeps the last LAT entries and
// derives the required value of out from them: zero if any of those edges
// saw reset, otherwise the product of the oldest entry.
// LAT follows the MUL_UNIT_PIPE_EN build option.
// -----------------------------------------------------------------------------
module tb_mul_unit;

`ifdef MUL_UNIT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int N_RANDOM = 20000;

  typedef struct {
    logic [31:0] prod;
    bit          rst;
    string       name;
  } item_t;

  logic        clk = 1'b1;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] out;

  item_t sb_q [$];
  item_t win  [$];
  bit    drv_done = 1'b0;
  bit    mon_done = 1'b0;
  int    n_vec = 0;
  int    n_err = 0;

  logic [31:0] dir_a [6] = '{32'h12345678, 32'h11111111, 32'h33333333,
                             32'h7FFFFFFF, 32'h00000000, 32'hFFFFFFFF};
  logic [31:0] dir_b [6] = '{32'h87654321, 32'h22222222, 32'h44444444,
                             32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] corner [6] = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF,
                              32'h7FFFFFFF, 32'h80000000, 32'hAAAAAAAA};

  mul_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .out   (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: out=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the exact 64-bit product, reduced modulo 2^32.
  function automatic logic [31:0] ref_mul(input logic [31:0] x,
                                          input logic [31:0] y);
    logic [63:0] full;
    full = {32'd0, x} * {32'd0, y};
    return full[31:0];
  endfunction

  task automatic drive(input logic [31:0] x, input logic [31:0] y,
                       input bit rst, input string name);
    item_t it;
    @(negedge clk);
    a     = x;
    b     = y;
    rst_n = ~rst;
    it.prod = ref_mul(x, y);
    it.rst  = rst;
    it.name = name;
    sb_q.push_back(it);
  endtask

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 7) == 0) return corner[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  // Driver
  initial begin
    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    for (int i = 0; i < 3; i++) drive(dir_a[0], dir_b[0], 1'b1, "reset_hold");
    for (int i = 0; i < 6; i++) drive(dir_a[i], dir_b[i], 1'b0, $sformatf("stream_%0d", i));
    for (int i = 0; i < 6; i++) drive(dir_a[i], dir_b[i], i == 3, $sformatf("midrst_%0d", i));
    for (int i = 0; i < 4; i++) drive(dir_a[1], dir_b[1], 1'b0, "held");
    for (int i = 0; i < N_RANDOM; i++)
      drive(pick(), pick(), $urandom_range(0, 199) == 0, "random");
    for (int i = 0; i < LAT + 1; i++) drive(32'h0000_0003, 32'h0000_0005, 1'b0, "drain");
    @(negedge clk);
    drv_done = 1'b1;
  end

  // Monitor
  initial begin
    item_t       it;
    logic [31:0] exp;
    bit          zero;
    while (1) begin
      @(posedge clk);
      #1;
      if (drv_done && sb_q.size() == 0) break;
      if (sb_q.size() == 0) begin
        check("scoreboard_empty", out, 32'hxxxxxxxx);
      end else begin
        it = sb_q.pop_front();
        win.push_back(it);
        if (win.size() > LAT) void'(win.pop_front());
        zero = (win.size() < LAT);
        foreach (win[i]) if (win[i].rst) zero = 1'b1;
        exp = zero ? 32'd0 : win[0].prod;
        check(it.name, out, exp);
      end
    end
    mon_done = 1'b1;
  end

  // Watchdog
  initial begin
    #((N_RANDOM + 200) * 10 * 2);
    $display("FAIL watchdog: run did not complete, %0d checks so far", n_vec);
    $fatal(1, "timeout");
  end

  initial begin
    wait (mon_done);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
